memory_dump_reader: RTL



---
 rtl/memory_dump_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/memory_dump_reader.sv
// memory_dump_reader
//   Memory-bus read initiator that streams a contiguous byte range of global
//   memory out as a byte stream, one bus word fetched per aligned 8-byte group
//   touched by the range, with a single read outstanding at a time.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   start                  one-cycle dump request, sampled only when idle
//   base_addr, byte_len    first byte address (any alignment), byte count
//   busy, done             busy from accept until done inclusive; done pulse
//   mem_req_valid/ready    read request handshake, mem_req_addr word-aligned
//   mem_resp_valid/data    one-cycle read response, little-endian word
//   out_valid/ready        byte stream handshake
//   out_data, out_addr     byte value and its byte address
//   out_last               final byte of the dump
//
// state   | meaning
// S_IDLE  | waiting for start
// S_REQ   | read request presented, held until accepted
// S_WAIT  | request accepted, waiting for the response word
// S_STREAM| emitting bytes of the buffered word
// S_DONE  | done pulse, back to idle next cycle

module memory_dump_reader #(
  parameter int ADDR_WIDTH = 21,
  parameter int LEN_WIDTH  = 21,
  parameter int WORD_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    byte_len,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [WORD_BYTES*8-1:0] mem_resp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic                    out_last
);

  localparam int OFF_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STREAM, S_DONE} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [LEN_WIDTH-1:0]    remaining_q;
  logic [WORD_BYTES*8-1:0] word_q;
  logic                    busy_q, done_q, req_valid_q, out_valid_q, out_last_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q, out_addr_q;
  logic [7:0]              out_data_q;

  logic [ADDR_WIDTH-1:0]   addr_inc_d;
  logic [LEN_WIDTH-1:0]    rem_dec_d;
  logic [7:0]              resp_byte_d;
  logic [7:0]              next_byte_d;

  // Address increment wraps naturally at 2^ADDR_WIDTH.
  assign addr_inc_d  = cur_addr_q + ADDR_WIDTH'(1);
  assign rem_dec_d   = remaining_q - LEN_WIDTH'(1);
  // First byte comes straight off the bus; later bytes from the held word.
  assign resp_byte_d = mem_resp_data[{cur_addr_q[OFF_W-1:0], 3'b000} +: 8];
  assign next_byte_d = word_q[{addr_inc_d[OFF_W-1:0], 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (byte_len == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cur_addr_q  <= base_addr;
              remaining_q <= byte_len;
              req_valid_q <= 1'b1;
              req_addr_q  <= {base_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            word_q      <= mem_resp_data;
            out_valid_q <= 1'b1;
            out_data_q  <= resp_byte_d;
            out_addr_q  <= cur_addr_q;
            out_last_q  <= (remaining_q == LEN_WIDTH'(1));
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            cur_addr_q  <= addr_inc_d;
            remaining_q <= rem_dec_d;
            if (remaining_q == LEN_WIDTH'(1)) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else if (cur_addr_q[OFF_W-1:0] == '1) begin
              // Word exhausted: no prefetch, so the stream gaps while refetching.
              out_valid_q <= 1'b0;
              req_valid_q <= 1'b1;
              req_addr_q  <= {addr_inc_d[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
              state_q     <= S_REQ;
            end else begin
              out_data_q <= next_byte_d;
              out_addr_q <= addr_inc_d;
              out_last_q <= (rem_dec_d == LEN_WIDTH'(1));
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_addr      = out_addr_q;
  assign out_last      = out_last_q;

endmodule
